// File: rtl/encrypt_msg.sv
// -----------------------------------------------------------------------------
// encrypt_msg -- RC4-style stream encryption of MSG_LEN plaintext bytes.
//
// The S permutation lives in an external synchronous memory that a separate
// KSA block has already initialised. Each byte runs the PRGA step
// (i, j update, swap, keystream fetch) against that memory. The byte is then
// XORed with one plaintext byte, and the result is handed to the sink.
//
// Parameters
//   MSG_LEN        bytes encrypted per run (1..256)
// Optional feature
//   ENC_PRINTABLE_CHK_EN  when defined, plaintext other than space or 'a'..'z'
//                         aborts the run (INVALID_P / o_em_invalid)
// Ports
//   i_clk, i_rst_n            clock, async active-low reset
//   i_start                   level; starts a run from IDLE
//   i_pt_valid/i_pt_data      plaintext byte offered
//   o_pt_ready                one-cycle consume strobe (WAIT_PT only)
//   o_ct_valid/o_ct_data      ciphertext byte offered, i_ct_ready accepts
//   o_em_s_address/_data/_wren, i_em_s_q   S-memory port (2-cycle read latency)
//   o_em_done / o_em_invalid  run complete / run aborted, held until start low
// -----------------------------------------------------------------------------
module encrypt_msg #(
  parameter int MSG_LEN = 32
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_start,
  input  logic       i_pt_valid,
  input  logic [7:0] i_pt_data,
  output logic       o_pt_ready,
  output logic       o_ct_valid,
  output logic [7:0] o_ct_data,
  input  logic       i_ct_ready,
  output logic [7:0] o_em_s_address,
  output logic [7:0] o_em_s_data,
  output logic       o_em_s_wren,
  input  logic [7:0] i_em_s_q,
  output logic       o_em_done,
  output logic       o_em_invalid
);

  typedef enum logic [4:0] {
    IDLE, INC_I, LOAD_I, READ_I, SAVE_I, CALC_J, LOAD_J, READ_J, SAVE_J,
    WRITE_I, WRITE_J, CALC_F, LOAD_F, READ_F, SAVE_F, WAIT_PT, SEND_CT,
    CHK_DONE, INC_K, DONE, INVALID_P
  } state_t;

  localparam logic [7:0] K_LAST = 8'(MSG_LEN - 1);

  state_t     r_state;
  logic [7:0] r_i, r_j, r_k, r_si, r_sj, r_f, r_ct;
  logic [7:0] r_addr, r_wdata;
  logic       r_wren, r_ct_valid, r_done, r_invalid;

  logic       w_pt_take;
  logic       w_pt_ok;

  // Consume strobe must coincide with the cycle pt_data is sampled, so it is
  // the only output decoded combinationally from state.
  assign w_pt_take = (r_state == WAIT_PT) && i_pt_valid;

`ifdef ENC_PRINTABLE_CHK_EN
  assign w_pt_ok = (i_pt_data == 8'h20) ||
                   ((i_pt_data >= 8'h61) && (i_pt_data <= 8'h7A));
`else
  assign w_pt_ok = 1'b1;
`endif

  // Outputs are registered: each state sets the values the *next* state
  // presents, so the address is already on the bus when LOAD_x is entered.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= IDLE;
      r_i        <= 8'h00;
      r_j        <= 8'h00;
      r_k        <= 8'h00;
      r_si       <= 8'h00;
      r_sj       <= 8'h00;
      r_f        <= 8'h00;
      r_ct       <= 8'h00;
      r_addr     <= 8'h00;
      r_wdata    <= 8'h00;
      r_wren     <= 1'b0;
      r_ct_valid <= 1'b0;
      r_done     <= 1'b0;
      r_invalid  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (i_start) begin
          r_i     <= 8'h00;
          r_j     <= 8'h00;
          r_k     <= 8'h00;
          r_state <= INC_I;
        end
        INC_I: begin
          r_i     <= r_i + 8'd1;
          r_addr  <= r_i + 8'd1;
          r_state <= LOAD_I;
        end
        LOAD_I: r_state <= READ_I;
        READ_I: r_state <= SAVE_I;
        SAVE_I: begin
          r_si    <= i_em_s_q;
          r_state <= CALC_J;
        end
        CALC_J: begin
          r_j     <= r_j + r_si;
          r_addr  <= r_j + r_si;
          r_state <= LOAD_J;
        end
        LOAD_J: r_state <= READ_J;
        READ_J: r_state <= SAVE_J;
        SAVE_J: begin
          // Swap: S[i] <= sj first, then S[j] <= si. With i==j both writes
          // carry the same value, leaving S unchanged.
          r_sj    <= i_em_s_q;
          r_addr  <= r_i;
          r_wdata <= i_em_s_q;
          r_wren  <= 1'b1;
          r_state <= WRITE_I;
        end
        WRITE_I: begin
          r_addr  <= r_j;
          r_wdata <= r_si;
          r_state <= WRITE_J;
        end
        WRITE_J: begin
          r_wren  <= 1'b0;
          r_state <= CALC_F;
        end
        CALC_F: begin
          r_addr  <= r_si + r_sj;
          r_state <= LOAD_F;
        end
        LOAD_F: r_state <= READ_F;
        READ_F: r_state <= SAVE_F;
        SAVE_F: begin
          r_f     <= i_em_s_q;
          r_state <= WAIT_PT;
        end
        WAIT_PT: if (w_pt_take) begin
          if (w_pt_ok) begin
            r_ct       <= i_pt_data ^ r_f;
            r_ct_valid <= 1'b1;
            r_state    <= SEND_CT;
          end else begin
            r_invalid <= 1'b1;
            r_state   <= INVALID_P;
          end
        end
        SEND_CT: if (i_ct_ready) begin
          r_ct_valid <= 1'b0;
          r_state    <= CHK_DONE;
        end
        CHK_DONE: begin
          if (r_k == K_LAST) begin
            r_done  <= 1'b1;
            r_state <= DONE;
          end else begin
            r_state <= INC_K;
          end
        end
        INC_K: begin
          r_k     <= r_k + 8'd1;
          r_state <= INC_I;
        end
        DONE: if (!i_start) begin
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
        INVALID_P: if (!i_start) begin
          r_invalid <= 1'b0;
          r_state   <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_pt_ready     = w_pt_take;
  assign o_ct_valid     = r_ct_valid;
  assign o_ct_data      = r_ct;
  assign o_em_s_address = r_addr;
  assign o_em_s_data    = r_wdata;
  assign o_em_s_wren    = r_wren;
  assign o_em_done      = r_done;
  assign o_em_invalid   = r_invalid;

endmodule

// File: tb/tb_encrypt_msg.sv
// -----------------------------------------------------------------------------
// tb_encrypt_msg -- directed bench for encrypt_msg.
// u0: MSG_LEN=2 for hand-computed vectors; u1: MSG_LEN=256 for wrap/count.
// Each DUT talks to a local S-memory model with two-cycle read latency.
// -----------------------------------------------------------------------------
module tb_encrypt_msg;

  logic       clk = 1'b0;
  logic       rst_n;
  always #5 clk = ~clk;

  // ---- u0 signals
  logic       start0, pt_valid0, pt_ready0, ct_valid0, ct_ready0;
  logic [7:0] pt_data0, ct_data0, addr0, wdata0, q0, p0;
  logic       wren0, done0, invalid0, init0;
  logic [7:0] mem0 [256];

  // ---- u1 signals
  logic       start1, pt_valid1, pt_ready1, ct_valid1, ct_ready1;
  logic [7:0] pt_data1, ct_data1, addr1, wdata1, q1, p1;
  logic       wren1, done1, invalid1, init1;
  logic [7:0] mem1 [256];

  int tests = 0;
  int fails = 0;

  encrypt_msg #(.MSG_LEN(2)) u0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start0),
    .i_pt_valid(pt_valid0), .i_pt_data(pt_data0), .o_pt_ready(pt_ready0),
    .o_ct_valid(ct_valid0), .o_ct_data(ct_data0), .i_ct_ready(ct_ready0),
    .o_em_s_address(addr0), .o_em_s_data(wdata0), .o_em_s_wren(wren0),
    .i_em_s_q(q0), .o_em_done(done0), .o_em_invalid(invalid0));

  encrypt_msg #(.MSG_LEN(256)) u1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start1),
    .i_pt_valid(pt_valid1), .i_pt_data(pt_data1), .o_pt_ready(pt_ready1),
    .o_ct_valid(ct_valid1), .o_ct_data(ct_data1), .i_ct_ready(ct_ready1),
    .o_em_s_address(addr1), .o_em_s_data(wdata1), .o_em_s_wren(wren1),
    .i_em_s_q(q1), .o_em_done(done1), .o_em_invalid(invalid1));

  // S-memory models: init loads identity permutation
  always @(posedge clk) begin
    if (init0) for (int n = 0; n < 256; n++) mem0[n] <= 8'(n);
    else if (wren0) mem0[addr0] <= wdata0;
    p0 <= mem0[addr0];
    q0 <= p0;
  end

  always @(posedge clk) begin
    if (init1) for (int n = 0; n < 256; n++) mem1[n] <= 8'(n);
    else if (wren1) mem1[addr1] <= wdata1;
    p1 <= mem1[addr1];
    q1 <= p1;
  end

  // u1 observers
  int         hs1 = 0, pr1 = 0, drise1 = 0;
  logic       done1_d = 1'b0, wphase1 = 1'b0;
  logic [7:0] last_wi1 = 8'hFF, first_ct1 = 8'hFF;
  always @(posedge clk) begin
    if (ct_valid1 && ct_ready1) begin
      if (hs1 == 0) first_ct1 <= ct_data1;
      hs1 <= hs1 + 1;
    end
    if (pt_ready1) pr1 <= pr1 + 1;
    done1_d <= done1;
    if (done1 && !done1_d) drise1 <= drise1 + 1;
    if (wren1) begin
      if (!wphase1) last_wi1 <= addr1;
      wphase1 <= ~wphase1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic push0(input logic [7:0] d);
    int n = 0;
    pt_valid0 = 1'b1; pt_data0 = d; #1;
    while (!pt_ready0 && n < 200) begin @(negedge clk); #1; n++; end
    chk("pt_ready", {31'd0, pt_ready0}, 32'd1);
    @(negedge clk);
    pt_valid0 = 1'b0;
  endtask

  task automatic get0(input logic [7:0] exp);
    int n = 0;
    while (!ct_valid0 && n < 200) begin @(negedge clk); n++; end
    chk("ct_valid", {31'd0, ct_valid0}, 32'd1);
    chk("ct_data", {24'd0, ct_data0}, {24'd0, exp});
    @(negedge clk);
  endtask

  task automatic wait_done0;
    int n = 0;
    while (!done0 && n < 50) begin @(negedge clk); n++; end
    chk("em_done", {31'd0, done0}, 32'd1);
  endtask

  task automatic load_s;
    init0 = 1'b1; init1 = 1'b1;
    @(negedge clk);
    init0 = 1'b0; init1 = 1'b0;
  endtask

  initial begin
    int hi;
    rst_n = 1'b0;
    start0 = 0; pt_valid0 = 0; pt_data0 = 0; ct_ready0 = 1; init0 = 0;
    start1 = 0; pt_valid1 = 0; pt_data1 = 0; ct_ready1 = 1; init1 = 0;
    #2;
    chk("rst ct_valid", {31'd0, ct_valid0}, 0);
    chk("rst wren",     {31'd0, wren0}, 0);
    chk("rst done",     {31'd0, done0}, 0);
    chk("rst addr",     {24'd0, addr0}, 0);
    chk("rst ct_data",  {24'd0, ct_data0}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    load_s();

    // Run A: 0x61,0x62 -> 0x63,0x67
    start0 = 1'b1;
    push0(8'h61); get0(8'h63);
    push0(8'h62); get0(8'h67);
    wait_done0();
    chk("S[2]", {24'd0, mem0[2]}, 32'd3);
    chk("S[3]", {24'd0, mem0[3]}, 32'd2);
    chk("S[1]", {24'd0, mem0[1]}, 32'd1);
    @(negedge clk);
    chk("done held", {31'd0, done0}, 32'd1);
    start0 = 1'b0;
    repeat (2) @(negedge clk);
    chk("done clr", {31'd0, done0}, 0);

    // Run B: pt starvation, then sink backpressure
    load_s();
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;  // ignored mid-run
    repeat (30) @(negedge clk);
    hi = 0;
    for (int c = 0; c < 10; c++) begin
      if (pt_ready0 || ct_valid0) hi++;
      @(negedge clk);
    end
    chk("starve idle", hi, 0);
    ct_ready0 = 1'b0;
    push0(8'h61);
    for (int c = 0; c < 5; c++) begin
      chk("stall ct_valid", {31'd0, ct_valid0}, 32'd1);
      chk("stall ct_data",  {24'd0, ct_data0}, 32'h63);
      chk("stall wren",     {31'd0, wren0}, 0);
      chk("stall addr",     {24'd0, addr0}, 32'h02);
      @(negedge clk);
    end
    ct_ready0 = 1'b1;
    get0(8'h63);
    push0(8'h62); get0(8'h67);
    wait_done0();
    repeat (2) @(negedge clk);

    // Run C: non-printable byte
    load_s();
    start0 = 1'b1;
`ifdef ENC_PRINTABLE_CHK_EN
    push0(8'h41);
    begin
      int n = 0;
      hi = 0;
      while (!invalid0 && n < 10) begin if (ct_valid0) hi++; @(negedge clk); n++; end
      chk("em_invalid", {31'd0, invalid0}, 32'd1);
      repeat (3) begin if (ct_valid0) hi++; @(negedge clk); end
      chk("no ct", hi, 0);
    end
    start0 = 1'b0;
    repeat (2) @(negedge clk);
    chk("invalid clr", {31'd0, invalid0}, 0);
`else
    push0(8'h41); get0(8'h43);
    push0(8'h00); get0(8'h05);
    wait_done0();
    chk("no invalid", {31'd0, invalid0}, 0);
    start0 = 1'b0;
    repeat (2) @(negedge clk);
`endif

    // Run D: reset during WRITE_J, then a clean rerun
    load_s();
    start0 = 1'b1;
    push0(8'h61); get0(8'h63);
    begin
      int n = 0;
      while (!wren0 && n < 50) begin @(negedge clk); n++; end
    end
    @(negedge clk);
    chk("in WRITE_J", {31'd0, wren0}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("arst wren",  {31'd0, wren0}, 0);
    chk("arst addr",  {24'd0, addr0}, 0);
    chk("arst wdata", {24'd0, wdata0}, 0);
    chk("arst ctd",   {24'd0, ct_data0}, 0);
    chk("arst ready", {31'd0, pt_ready0}, 0);
    start0 = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    load_s();
    start0 = 1'b1;
    push0(8'h61); get0(8'h63);
    push0(8'h62); get0(8'h67);
    wait_done0();
    start0 = 1'b0;
    repeat (2) @(negedge clk);

    // Run E: MSG_LEN=256 on u1
    load_s();
    start1 = 1'b1; pt_valid1 = 1'b1; pt_data1 = 8'h00;
    @(negedge clk);
    start1 = 1'b0;
    begin
      int n = 0;
      while (!done1 && n < 8000) begin @(negedge clk); n++; end
      chk("u1 done", {31'd0, done1}, 32'd1);
    end
    pt_valid1 = 1'b0;
    repeat (20) @(negedge clk);
    chk("u1 handshakes", hs1, 256);
    chk("u1 pt_ready",   pr1, 256);
    chk("u1 done once",  drise1, 1);
    chk("u1 i wrap",     {24'd0, last_wi1}, 0);
    chk("u1 first ct",   {24'd0, first_ct1}, 32'h02);
    chk("u1 invalid",    {31'd0, invalid1}, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
